// File: rtl/fb_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fb_port_arbiter: two-requester frame-RAM port-A arbiter with frame-synced page swap
// Rev 1.0
// ---------------------------------------------------------------------------
module fb_port_arbiter #(
  parameter int LADDR_W = 11,
  parameter int DATA_W  = 12
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [LADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0]  m0_wdata,
  output logic               m0_ack,
  output logic               m0_rvalid,
  output logic [DATA_W-1:0]  m0_rdata,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [LADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0]  m1_wdata,
  output logic               m1_ack,
  output logic               m1_rvalid,
  output logic [DATA_W-1:0]  m1_rdata,
  input  logic               swap_req,
  input  logic               frame_end,
  output logic               front_page,
  output logic               swap_pending,
  output logic [LADDR_W:0]   ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  output logic               ram_we,
  output logic               ram_re,
  input  logic [DATA_W-1:0]  ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RDW  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last;
  logic                r_gnt;
  logic                r_frame_seen;
  logic                w_swap_exec;
  logic                w_grant;
  logic                w_gnt_id;
  logic                w_gnt_we;
  logic                w_tie;
  logic [LADDR_W-1:0]  w_gnt_addr;
  logic [DATA_W-1:0]   w_gnt_wdata;

  always_comb begin
    w_swap_exec = 1'b0;
    w_grant     = 1'b0;
    w_gnt_id    = 1'b0;
    w_tie       = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        // A swap owns its IDLE cycle so no access can straddle the page change
        w_swap_exec = r_frame_seen | (frame_end & swap_pending);
        if (!w_swap_exec && (m0_req || m1_req)) begin
          w_grant = 1'b1;
          w_tie   = m0_req & m1_req;
          if (w_tie) begin
            w_gnt_id = ~r_last;
          end else begin
            w_gnt_id = m1_req;
          end
          w_state_nxt = (w_gnt_id ? m1_we : m0_we) ? S_WR : S_RD;
        end
      end
      S_WR:    w_state_nxt = S_IDLE;
      S_RD:    w_state_nxt = S_RDW;
      S_RDW:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_gnt_we    = w_gnt_id ? m1_we    : m0_we;
    w_gnt_addr  = w_gnt_id ? m1_addr  : m0_addr;
    w_gnt_wdata = w_gnt_id ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_last    <= 1'b1;
      r_gnt     <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (w_grant) begin
        r_gnt     <= w_gnt_id;
        ram_addr  <= {~front_page, w_gnt_addr};
        ram_wdata <= w_gnt_wdata;
        ram_we    <= w_gnt_we;
        ram_re    <= ~w_gnt_we;
        m0_ack    <= ~w_gnt_id;
        m1_ack    <= w_gnt_id;
        if (w_tie) begin
          r_last <= w_gnt_id;
        end
      end
      if (r_state == S_RDW) begin
        if (r_gnt) begin
          m1_rdata  <= ram_rdata;
          m1_rvalid <= 1'b1;
        end else begin
          m0_rdata  <= ram_rdata;
          m0_rvalid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      front_page   <= 1'b0;
      swap_pending <= 1'b0;
      r_frame_seen <= 1'b0;
    end else if (w_swap_exec) begin
      front_page   <= ~front_page;
      swap_pending <= 1'b0;
      r_frame_seen <= 1'b0;
    end else begin
      if (swap_req) begin
        swap_pending <= 1'b1;
      end
      // Frame ended mid-access: remember it and swap on the next IDLE cycle
      if ((r_state != S_IDLE) && frame_end && swap_pending) begin
        r_frame_seen <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fb_port_arbiter: vector table, directed swap/reset sequences, random run
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fb_port_arbiter;

  localparam int LADDR_W = 11;
  localparam int DATA_W  = 12;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b0;
  logic               m0_req = 1'b0, m0_we = 1'b0;
  logic [LADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0]  m0_wdata = '0;
  logic               m0_ack, m0_rvalid;
  logic [DATA_W-1:0]  m0_rdata;
  logic               m1_req = 1'b0, m1_we = 1'b0;
  logic [LADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0]  m1_wdata = '0;
  logic               m1_ack, m1_rvalid;
  logic [DATA_W-1:0]  m1_rdata;
  logic               swap_req = 1'b0, frame_end = 1'b0;
  logic               front_page, swap_pending;
  logic [LADDR_W:0]   ram_addr;
  logic [DATA_W-1:0]  ram_wdata;
  logic               ram_we, ram_re;
  logic [DATA_W-1:0]  ram_rdata = '0;

  fb_port_arbiter #(.LADDR_W(LADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .swap_req(swap_req), .frame_end(frame_end),
    .front_page(front_page), .swap_pending(swap_pending),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdata(ram_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Frame RAM port A: registered read, one cycle latency
  logic [DATA_W-1:0] mem [0:4095];
  always @(posedge i_clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drop_reqs();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  typedef struct {
    logic               r0;
    logic               w0;
    logic [LADDR_W-1:0] a0;
    logic [DATA_W-1:0]  d0;
    logic               r1;
    logic               w1;
    logic [LADDR_W-1:0] a1;
    logic [DATA_W-1:0]  d1;
    logic               exp_id;
    logic [LADDR_W:0]   exp_addr;
    logic               exp_we;
    logic [DATA_W-1:0]  exp_wd;
    logic [DATA_W-1:0]  exp_rd;
  } vec_t;

  vec_t tbl [10];

  // Random-phase reference state
  logic               pend [2];
  logic               rq_we [2];
  logic [LADDR_W-1:0] rq_addr [2];
  logic [DATA_W-1:0]  rq_wd [2];
  int                 cool [2];
  int                 waitc [2];
  int                 rv_at [2];
  logic               rv_known [2];
  logic [DATA_W-1:0]  rv_exp [2];
  logic [DATA_W-1:0]  image [int];
  logic               m_last, last_known;
  logic               mf, mp, sw_tgt, pg_prev, pg_known;
  int                 sw_cnt;
  int                 cyc;

  initial begin
    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_outputs_low", {m0_ack, m1_ack, m0_rvalid, m1_rvalid, ram_we, ram_re,
                            front_page, swap_pending}, 0);
    i_rst = 1'b1;
    tick();
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    chk("rst_front_page", front_page, 0);

    // ---------------- contention: both hold writes ----------------
    m0_req = 1; m0_we = 1; m0_addr = 11'h100; m0_wdata = 12'h001;
    m1_req = 1; m1_we = 1; m1_addr = 11'h200; m1_wdata = 12'h002;
    for (int t = 1; t <= 7; t++) begin
      tick();
      chk($sformatf("contend_ack0_t%0d", t), m0_ack, ((t % 4) == 1));
      chk($sformatf("contend_ack1_t%0d", t), m1_ack, ((t % 4) == 3));
    end
    drop_reqs();
    tick();

    // ---------------- vector table ----------------
    tbl[0] = '{1, 1, 11'h7FF, 12'h222, 1, 1, 11'h000, 12'h333, 0, 12'hFFF, 1, 12'h222, 12'h000};
    tbl[1] = '{1, 1, 11'h001, 12'h444, 1, 1, 11'h000, 12'h333, 1, 12'h800, 1, 12'h333, 12'h000};
    tbl[2] = '{1, 1, 11'h123, 12'hABC, 0, 0, 11'h000, 12'h000, 0, 12'h923, 1, 12'hABC, 12'h000};
    tbl[3] = '{0, 0, 11'h000, 12'h000, 1, 1, 11'h045, 12'h111, 1, 12'h845, 1, 12'h111, 12'h000};
    tbl[4] = '{1, 0, 11'h123, 12'h000, 0, 0, 11'h000, 12'h000, 0, 12'h923, 0, 12'h000, 12'hABC};
    tbl[5] = '{0, 0, 11'h000, 12'h000, 1, 0, 11'h045, 12'h000, 1, 12'h845, 0, 12'h000, 12'h111};
    tbl[6] = '{0, 0, 11'h000, 12'h000, 1, 0, 11'h000, 12'h000, 1, 12'h800, 0, 12'h000, 12'h333};
    tbl[7] = '{1, 0, 11'h7FF, 12'h000, 0, 0, 11'h000, 12'h000, 0, 12'hFFF, 0, 12'h000, 12'h222};
    tbl[8] = '{1, 1, 11'h010, 12'h5A5, 0, 0, 11'h000, 12'h000, 0, 12'h810, 1, 12'h5A5, 12'h000};
    tbl[9] = '{0, 0, 11'h000, 12'h000, 1, 0, 11'h010, 12'h000, 1, 12'h810, 0, 12'h000, 12'h5A5};
    for (int v = 0; v < 10; v++) begin
      m0_req = tbl[v].r0; m0_we = tbl[v].w0; m0_addr = tbl[v].a0; m0_wdata = tbl[v].d0;
      m1_req = tbl[v].r1; m1_we = tbl[v].w1; m1_addr = tbl[v].a1; m1_wdata = tbl[v].d1;
      tick();
      chk($sformatf("v%0d_ack0", v), m0_ack, !tbl[v].exp_id);
      chk($sformatf("v%0d_ack1", v), m1_ack, tbl[v].exp_id);
      chk($sformatf("v%0d_ram_addr", v), ram_addr, tbl[v].exp_addr);
      chk($sformatf("v%0d_ram_we", v), ram_we, tbl[v].exp_we);
      chk($sformatf("v%0d_ram_re", v), ram_re, !tbl[v].exp_we);
      if (tbl[v].exp_we) chk($sformatf("v%0d_ram_wdata", v), ram_wdata, tbl[v].exp_wd);
      drop_reqs();
      tick();
      if (!tbl[v].exp_we) begin
        chk($sformatf("v%0d_rvalid_early", v), m0_rvalid | m1_rvalid, 0);
        tick();
        chk($sformatf("v%0d_rvalid0", v), m0_rvalid, !tbl[v].exp_id);
        chk($sformatf("v%0d_rvalid1", v), m1_rvalid, tbl[v].exp_id);
        chk($sformatf("v%0d_rdata", v), tbl[v].exp_id ? m1_rdata : m0_rdata, tbl[v].exp_rd);
      end
    end

    // ---------------- deferred swap (frame end during RD) ----------------
    swap_req = 1; tick(); swap_req = 0;
    chk("dsw_pending_set", swap_pending, 1);
    m0_req = 1; m0_we = 0; m0_addr = 11'h123;
    tick();
    chk("dsw_rd_ack", {m0_ack, ram_re}, 2'b11);
    drop_reqs(); frame_end = 1;
    tick();
    frame_end = 0;
    chk("dsw_pending_rdw", swap_pending, 1);
    chk("dsw_front_rdw", front_page, 0);
    m0_req = 1; m0_we = 1; m0_addr = 11'h055; m0_wdata = 12'h666;
    tick();
    chk("dsw_rvalid", m0_rvalid, 1);
    chk("dsw_rdata", m0_rdata, 12'hABC);
    chk("dsw_pending_idle", swap_pending, 1);
    chk("dsw_front_idle", front_page, 0);
    tick();
    chk("dsw_front_flip", front_page, 1);
    chk("dsw_pending_clr", swap_pending, 0);
    chk("dsw_no_grant", {m0_ack, m1_ack, ram_we, ram_re}, 0);
    tick();
    chk("dsw_wr_ack", {m0_ack, ram_we}, 2'b11);
    chk("dsw_wr_addr", ram_addr, 12'h055);
    chk("dsw_wr_data", ram_wdata, 12'h666);
    drop_reqs();
    tick();

    // ---------------- swap_req with frame_end, then idle swap ----------------
    swap_req = 1; frame_end = 1; tick(); swap_req = 0; frame_end = 0;
    chk("sim_pending_only", swap_pending, 1);
    chk("sim_front_kept", front_page, 1);
    tick();
    frame_end = 1; tick(); frame_end = 0;
    chk("idle_swap_1cyc", front_page, 0);
    chk("idle_swap_pend_clr", swap_pending, 0);
    frame_end = 1; tick(); frame_end = 0;
    chk("fe_no_pending", {front_page, swap_pending}, 0);

    // ---------------- reset during RDW ----------------
    swap_req = 1; tick(); swap_req = 0;
    frame_end = 1; tick(); frame_end = 0;
    chk("pre_rst_front", front_page, 1);
    m1_req = 1; m1_we = 0; m1_addr = 11'h010;
    tick();
    chk("pre_rst_rd_ack", m1_ack, 1);
    drop_reqs();
    tick();
    i_rst = 0;
    #1;
    chk("mrst_front", front_page, 0);
    chk("mrst_strobes", {m0_ack, m1_ack, ram_we, ram_re, swap_pending}, 0);
    tick();
    chk("mrst_no_rvalid_a", m1_rvalid, 0);
    i_rst = 1;
    tick();
    chk("mrst_no_rvalid_b", m1_rvalid, 0);
    m0_req = 1; m0_we = 1; m0_addr = 11'h200; m0_wdata = 12'h777;
    tick();
    chk("mrst_idle_grant", m0_ack, 1);
    chk("mrst_addr", ram_addr, 12'hA00);
    drop_reqs();
    tick();

    // ---------------- randomized run against reference model ----------------
    i_rst = 0; tick(); tick(); i_rst = 1;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; cool[i] = 0; waitc[i] = 0; rv_at[i] = -1; rv_known[i] = 0;
      rq_we[i] = 0; rq_addr[i] = '0; rq_wd[i] = '0; rv_exp[i] = '0;
    end
    image.delete();
    m_last = 1; last_known = 1;
    mf = 0; mp = 0; sw_tgt = 0; sw_cnt = 0; pg_prev = 0; pg_known = 1;
    cyc = 0;
    for (int t = 0; t < 3000; t++) begin
      logic [1:0]        acks;
      logic [1:0]        rvals;
      logic              exp_pg;
      logic              exp_win;
      int                key;
      tick();
      cyc++;
      acks  = {m1_ack, m0_ack};
      rvals = {m1_rvalid, m0_rvalid};
      chk("rnd_ack_onehot", m0_ack & m1_ack, 0);
      chk("rnd_strobe_ack", ram_we | ram_re, m0_ack | m1_ack);
      for (int i = 0; i < 2; i++) begin
        if (acks[i]) begin
          exp_pg = ~pg_prev;
          key = int'({exp_pg, rq_addr[i]});
          chk($sformatf("rnd_ack%0d_has_req", i), pend[i], 1);
          chk($sformatf("rnd_ack%0d_addr", i), ram_addr[LADDR_W-1:0], rq_addr[i]);
          if (pg_known) chk($sformatf("rnd_ack%0d_page", i), ram_addr[LADDR_W], exp_pg);
          chk($sformatf("rnd_ack%0d_we", i), ram_we, rq_we[i]);
          if (rq_we[i]) begin
            chk($sformatf("rnd_ack%0d_wdata", i), ram_wdata, rq_wd[i]);
            if (pg_known) image[key] = rq_wd[i];
          end else begin
            rv_at[i]    = cyc + 2;
            rv_known[i] = pg_known && image.exists(key);
            rv_exp[i]   = rv_known[i] ? image[key] : '0;
          end
          if (pend[0] && pend[1]) begin
            exp_win = ~m_last;
            if (last_known) chk("rnd_rr_tie", i, exp_win);
            m_last = (i == 1);
            last_known = 1;
          end else begin
            last_known = 0;
          end
          pend[i] = 0; cool[i] = 2; waitc[i] = 0;
        end
      end
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("rnd_rvalid%0d", i), rvals[i], (rv_at[i] == cyc));
        if ((rv_at[i] == cyc) && rv_known[i])
          chk($sformatf("rnd_rdata%0d", i), (i == 1) ? m1_rdata : m0_rdata, rv_exp[i]);
        if (pend[i]) begin
          waitc[i]++;
          chk($sformatf("rnd_starve%0d", i), (waitc[i] > 12), 0);
        end
      end
      if (sw_cnt > 0) begin
        if (front_page == sw_tgt) begin
          chk("rnd_swap_pend_clr", swap_pending, 0);
          mf = sw_tgt; sw_cnt = 0;
        end else begin
          sw_cnt--;
          if (sw_cnt == 0) begin
            chk("rnd_swap_latency", front_page, sw_tgt);
            mf = sw_tgt;
          end
        end
      end else begin
        chk("rnd_front", front_page, mf);
        chk("rnd_pending", swap_pending, mp);
      end
      pg_prev  = mf;
      pg_known = (sw_cnt == 0);
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          if (cool[i] > 0) cool[i]--;
          else if ($urandom_range(0, 2) == 0) begin
            pend[i]    = 1;
            rq_we[i]   = ($urandom_range(0, 1) == 1);
            rq_addr[i] = 11'($urandom_range(0, 15));
            rq_wd[i]   = 12'($urandom);
            waitc[i]   = 0;
          end
        end
      end
      m0_req = pend[0]; m0_we = rq_we[0]; m0_addr = rq_addr[0]; m0_wdata = rq_wd[0];
      m1_req = pend[1]; m1_we = rq_we[1]; m1_addr = rq_addr[1]; m1_wdata = rq_wd[1];
      swap_req = 0; frame_end = 0;
      if (sw_cnt == 0) begin
        swap_req  = ($urandom_range(0, 15) == 0);
        frame_end = ($urandom_range(0, 9) == 0);
        if (frame_end && mp) begin
          sw_tgt = ~mf; mp = 0; sw_cnt = 3;
        end else if (swap_req) begin
          mp = 1;
        end
      end
    end
    drop_reqs(); swap_req = 0; frame_end = 0;
    tick(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Arbitrates two frame-buffer requesters (host bus and a bulk loader) onto port A of the panel's dual-port frame RAM, and manages double buffering. All requester accesses target the back page. Swap requests are deferred to the display's end-of-frame pulse, so a frame is never shown half-drawn. The `front_page` output drives the display-side base address, and the block sits between the requesters and `rgb_display`'s memory IO.

## Interface
- `LADDR_W`, 11, logical (per-page) word address width; the RAM address is `LADDR_W+1` bits, with the page bit as MSB.
- `DATA_W`, 12, pixel word width (RGB444).
- `i_clk`  in  1  system clock; same clock as RAM port A.
- `i_rst`  in  1  reset, asynchronous, active-low.
- `m0_req`, `m1_req`  in  1  access request; held until the matching `ack`.
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; held stable with `req`.
- `m0_addr`, `m1_addr`  in  `LADDR_W`  logical word address.
- `m0_wdata`, `m1_wdata`  in  `DATA_W`  write data.
- `m0_ack`, `m1_ack`  out  1  one-cycle pulse; marks the access issued to RAM.
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle pulse; read data valid.
- `m0_rdata`, `m1_rdata`  out  `DATA_W`  read data; holds its value until the next read for that requester.
- `swap_req`  in  1  pulse; request a page swap.
- `frame_end`  in  1  pulse from the display controller at the end of a frame.
- `front_page`  out  1  page currently displayed.
- `swap_pending`  out  1  a swap has been requested but not yet performed.
- `ram_addr`  out  `LADDR_W+1`  to RAM `addr_a`.
- `ram_wdata`  out  `DATA_W`  to RAM `data_in_a`.
- `ram_we`, `ram_re`  out  1  to RAM `wr_en` / `rd_en`.
- `ram_rdata`  in  `DATA_W`  from RAM `data_out_a`; valid one cycle after `ram_re`.

## Operation
- **Reset values:** every output is 0. The FSM is in IDLE. The round-robin pointer `last` = 1, so m0 wins the first tie. `frame_seen` = 0.
- **FSM states:** IDLE, WR, RD, RDW.
- **IDLE:**
  - If `frame_seen`, or a swap executes this cycle, no grant is issued.
  - Otherwise, if any `req` is high, grant one requester.
  - Single requester: grant it. Both requesting: grant the one ≠ `last`, then set `last` to the granted requester.
  - On grant, register `ram_addr = {~front_page, mX_addr}` and `ram_wdata = mX_wdata`, and store the grant id.
  - Next state is WR if `we`, else RD.
- **WR:** `ram_we` = 1 and `mX_ack` = 1 for this cycle. Next state IDLE.
- **RD:** `ram_re` = 1 and `mX_ack` = 1 for this cycle. Next state RDW.
- **RDW:** register `ram_rdata` into `mX_rdata` and pulse `mX_rvalid` on the following cycle. Next state IDLE.
- **Requester rule:** `req` must drop in the cycle after `ack`. If `req` is still high in IDLE, it counts as a new request.
- **Swap handling:**
  - `swap_req` sets `swap_pending`. A `swap_req` while already pending is ignored.
  - `frame_end` with `swap_pending` set, in IDLE: toggle `front_page` and clear `swap_pending` on the next edge.
  - `frame_end` with `swap_pending` set, in WR/RD/RDW: set `frame_seen`. The swap then executes on the first IDLE cycle, clearing `frame_seen`. No grant is issued in that IDLE cycle.
  - `frame_end` without `swap_pending`: no effect.
- **Simultaneous swap request and frame end:** `swap_req` and `frame_end` in the same cycle, with nothing pending, sets `swap_pending` only. The swap occurs at the next `frame_end`.
- **Page binding:** the page bit is bound when the grant is latched. An access already latched completes to the old back page.
- **Reset mid-operation:** any latched access is dropped without `ack` or `rvalid`, and `front_page` returns to 0.

## Timing
- **Write:** request sampled in IDLE at edge k. `ram_we` and `ack` are high in cycle k+1. Throughput is one write per 2 cycles.
- **Read:**
  - Request sampled at edge k.
  - `ram_re` and `ack` are high in cycle k+1.
  - `ram_rdata` is valid in cycle k+2.
  - `rvalid` and `rdata` are valid in cycle k+3.
  - Throughput is one read per 3 cycles.
- **Swap latency:** `front_page` changes at most 3 cycles after the qualifying `frame_end`. It changes 1 cycle after when the FSM is in IDLE.
- **Output sources:** all outputs are registered, with no combinational input-to-output paths.

## Test plan
- **Reset state:** hold `i_rst` = 0, then release. All outputs are 0 and `front_page` = 0.
- **m0 write:** m0 writes `addr` 0x123, data 0xABC. `ram_addr` = 0x923 (back page 1), `ram_we` and `m0_ack` pulse 1 cycle after the request, and no `m1_ack` occurs.
- **Contention:** m0 and m1 both hold write requests continuously. Grants alternate m0, m1, m0, m1, each requester getting an `ack` every 4 cycles.
- **m1 read:** m1 reads 0x010 while RAM returns 0x5A5. `ram_re` = 1 with `ram_addr` = 0x810, and `m1_rvalid` = 1 with `m1_rdata` = 0x5A5 exactly 3 cycles after the request.
- **Deferred swap:** pulse `swap_req`, then pulse `frame_end` while the FSM is in RD.
  - `swap_pending` = 1 until the read completes.
  - `front_page` flips to 1 at the first IDLE cycle, and no grant is issued in that cycle.
  - The next write goes to `ram_addr` MSB 0.
- **Reset mid-read:** assert `i_rst` in RDW. No `rvalid` is produced, the FSM is in IDLE, and `front_page` = 0.
